// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB transfer/burst encodings, beat-length constants and arbiter state type
package ahb_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } hburst_e;

    // Beats still to come after the NONSEQ beat of a fixed-length burst.
    localparam logic [3:0] BEATS_LOAD_4  = 4'd3;
    localparam logic [3:0] BEATS_LOAD_8  = 4'd7;
    localparam logic [3:0] BEATS_LOAD_16 = 4'd15;

    typedef enum logic [1:0] {
        ST_DEFAULT_GNT = 2'd0,
        ST_OWNED       = 2'd1,
        ST_BURST       = 2'd2
    } arb_state_e;

    function automatic logic [3:0] beat_load(input logic [2:0] burst);
        case (burst)
            BURST_WRAP4,  BURST_INCR4:  return BEATS_LOAD_4;
            BURST_WRAP8,  BURST_INCR8:  return BEATS_LOAD_8;
            BURST_WRAP16, BURST_INCR16: return BEATS_LOAD_16;
            default:                    return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin search: first set request at or after (ptr + 1) mod N
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [3:0]   ptr_i,
    output logic         found_o,
    output logic [3:0]   idx_o
);

    logic [4:0] cand;
    logic       found;
    logic [3:0] idx;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = {1'b0, ptr_i} + 5'(k);
            if (cand >= 5'(N)) begin
                cand = cand - 5'(N);
            end
            for (int i = 0; i < N; i++) begin
                if (!found && req_i[i] && cand == 5'(i)) begin
                    found = 1'b1;
                    idx   = 4'(i);
                end
            end
        end
        found_o = found;
        idx_o   = idx;
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// rtl/ahb_bus_arbiter.sv - AHB round-robin bus arbiter with burst-aware handover
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int N_MASTERS      = 2,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [N_MASTERS-1:0] HBUSREQ,
    input  logic [1:0]           HTRANS,
    input  logic [2:0]           HBURST,
    input  logic                 HREADY,
    output logic [N_MASTERS-1:0] HGRANT,
    output logic [3:0]           HMASTER,
    output logic [3:0]           HMASTER_D
);

    localparam logic [N_MASTERS-1:0] DEF_GRANT = N_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [3:0]           DEF_IDX   = 4'(DEFAULT_MASTER);

    arb_state_e           state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [3:0]           ptr_q, ptr_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [3:0]           hmaster_q, hmaster_d;
    logic [3:0]           hmaster_dph_q, hmaster_dph_d;
    logic [3:0]           owner_idx;
    logic [3:0]           pick_idx;
    logic                 pick_found;
    logic                 handover;

    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant_q[i]) begin
                owner_idx = 4'(i);
            end
        end
    end

    // The owner is masked out so it is only kept when nobody else asks.
    rr_pick #(
        .N(N_MASTERS)
    ) u_rr_pick (
        .req_i  (HBUSREQ & ~grant_q),
        .ptr_i  (ptr_q),
        .found_o(pick_found),
        .idx_o  (pick_idx)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (HREADY) begin
            if (HTRANS == TRANS_NONSEQ) begin
                cnt_d = beat_load(HBURST);
            end else if (HTRANS == TRANS_SEQ && state_q == ST_BURST) begin
                cnt_d = cnt_q - 4'd1;
            end
        end

        // Release on the last beat itself so the grant moves at its closing edge.
        handover = HREADY && (HTRANS != TRANS_BUSY) && (cnt_d == 4'd0);

        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (handover) begin
            if (pick_found) begin
                for (int i = 0; i < N_MASTERS; i++) begin
                    grant_d[i] = (4'(i) == pick_idx);
                end
                ptr_d = pick_idx;
            end else if (|HBUSREQ) begin
                ptr_d = owner_idx;
            end else begin
                grant_d = DEF_GRANT;
            end
        end

        state_d = state_q;
        if (HREADY) begin
            if (cnt_d != 4'd0) begin
                state_d = ST_BURST;
            end else if (grant_d == DEF_GRANT && !(|HBUSREQ)) begin
                state_d = ST_DEFAULT_GNT;
            end else begin
                state_d = ST_OWNED;
            end
        end

        hmaster_d     = HREADY ? owner_idx : hmaster_q;
        hmaster_dph_d = HREADY ? hmaster_q : hmaster_dph_q;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q       <= ST_DEFAULT_GNT;
            grant_q       <= DEF_GRANT;
            ptr_q         <= DEF_IDX;
            cnt_q         <= '0;
            hmaster_q     <= DEF_IDX;
            hmaster_dph_q <= DEF_IDX;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            hmaster_q     <= hmaster_d;
            hmaster_dph_q <= hmaster_dph_d;
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTER_D = hmaster_dph_q;

endmodule

// File: doc/ahb_bus_arbiter.md
AHB_BUS_ARBITER -- requirements
Module: ahb_bus_arbiter

Interface
- REQ-001 SHALL have parameter N_MASTERS, default 2, giving the number of bus masters (2..8); master 0 is the LCD DMA master.
- REQ-002 SHALL have parameter DEFAULT_MASTER, default 0, giving the master granted when there are no requests.
- REQ-003 Port HCLK, input, 1, is the single bus clock; all state updates on its rising edge.
- REQ-004 Port HRESET, input, 1, is the reset; it SHALL be synchronous and active-high.
- REQ-005 Port HBUSREQ, input, N_MASTERS, carries the per-master bus requests.
- REQ-006 Port HTRANS, input, 2, is the address-phase transfer type of the current owner (IDLE/BUSY/NONSEQ/SEQ).
- REQ-007 Port HBURST, input, 3, is the address-phase burst type of the current owner.
- REQ-008 Port HREADY, input, 1, is the slave ready signal; 1 means the current transfer completes this cycle.
- REQ-009 Port HGRANT, output, N_MASTERS, is the registered one-hot grant.
- REQ-010 Port HMASTER, output, 4, is the index of the address-phase owner.
- REQ-011 Port HMASTER_D, output, 4, is the index of the data-phase owner.

Function
- REQ-012 HGRANT SHALL be exactly one-hot in every cycle, including reset.
- REQ-013 Arbitration SHALL be evaluated only in "handover cycles": HREADY=1 and the bus is releasable.
- REQ-014 Releasable SHALL mean beat counter = 0 and HTRANS is not BUSY.
- REQ-015 Beat counter SHALL load on HREADY=1 with HTRANS=NONSEQ: INCR4/WRAP4 load 3, INCR8/WRAP8 load 7, INCR16/WRAP16 load 15; SINGLE/INCR load 0.
- REQ-016 Beat counter SHALL decrement by 1 on HREADY=1 with HTRANS=SEQ and counter>0; it never underflows.
- REQ-017 Arbitration SHALL be round-robin: search starts at (last granted index + 1) mod N_MASTERS and picks the first asserted HBUSREQ bit.
- REQ-018 The current owner SHALL be re-granted only if no other master requests.
- REQ-019 With no HBUSREQ bits set in a handover cycle, HGRANT SHALL move to DEFAULT_MASTER and the round-robin pointer SHALL be unchanged.
- REQ-020 A new grant SHALL appear at the clock edge ending the handover cycle, i.e. 1 cycle of latency from a visible request.
- REQ-021 Outside handover cycles HGRANT SHALL hold, even if the owner deasserts HBUSREQ mid-burst.
- REQ-022 HMASTER SHALL take the index of HGRANT on each edge with HREADY=1, and hold otherwise.
- REQ-023 HMASTER_D SHALL take the value of HMASTER on each edge with HREADY=1, and hold otherwise.
- REQ-024 Arbiter FSM states: DEFAULT_GNT (idle, default owner), OWNED (single/undefined-length transfers), BURST (beat counter>0).
- REQ-025 FSM transitions SHALL occur only on HREADY=1; BURST returns to OWNED/DEFAULT_GNT when the counter reaches 0.
- REQ-026 HREADY=0 SHALL freeze the beat counter, HGRANT, HMASTER and HMASTER_D.
- REQ-027 A request and a deassertion by different masters in the same handover cycle SHALL resolve by REQ-017 on the sampled values.

Reset
- REQ-028 HRESET=1 on an edge SHALL set HGRANT to one-hot(DEFAULT_MASTER), HMASTER and HMASTER_D to DEFAULT_MASTER, beat counter to 0, pointer to DEFAULT_MASTER, and FSM to DEFAULT_GNT.
- REQ-029 Reset mid-burst SHALL abandon the burst, with no residual beat count after release.

Structure
- REQ-030 The trans and burst encodings plus the beat-length constants SHALL live in a shared ahb_pkg package.
- REQ-031 The round-robin priority search SHALL be one combinational sub-module, rr_pick.

Verification
- REQ-032 Reset with HBUSREQ=2'b00 -> HGRANT=2'b01, HMASTER=0, HMASTER_D=0.
- REQ-033 HBUSREQ=2'b11 held, SINGLE NONSEQ each cycle, HREADY=1 -> HGRANT alternates 01,10,01, with HMASTER lagging one cycle.
- REQ-034 Master 0 INCR4 (NONSEQ+3 SEQ) while master 1 requests -> grant moves to master 1 only at the edge after the 4th beat.
- REQ-035 HREADY=0 for 3 cycles mid-INCR8 -> counter, HGRANT and HMASTER frozen; handover after the 8th beat.
- REQ-036 HRESET pulsed during beat 2 of INCR16 -> next cycle shows reset values; a subsequent SINGLE from master 1 is granted normally.
